// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. It scans the operands MSB-first, one CHUNK-bit slice
// per cycle, and stops at the first slice where they differ. It handles signed and
// unsigned operands and six relational ops.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CUW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             lt_flag,
  output logic             eq_flag,
  output logic [CUW-1:0]   chunks_used,
  output logic [1:0]       dbg_state_o
);

  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The request side is ready only in IDLE. The result is held while out_valid is high
  // and out_ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_magnitude_comparator: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             signed_q, signed_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             result_q, result_d, lt_q, lt_d, eq_q, eq_d;
  logic [CUW-1:0]   cu_q, cu_d;
  logic [CHUNK-1:0] slice_a, slice_b;

  function automatic logic eval_op(input logic [2:0] rel, input logic lt, input logic eq);
    case (rel)
      3'd0:    return lt;
      3'd1:    return lt | eq;
      3'd2:    return ~lt & ~eq;
      3'd3:    return ~lt;
      3'd4:    return eq;
      3'd5:    return ~eq;
      default: return 1'b0;
    endcase
  endfunction

  // Flipping the sign bit of the top slice turns the signed order into the unsigned order.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        slice_a = a_q[i*CHUNK +: CHUNK];
        slice_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (signed_q && idx_q == IDXW'(NCHUNK - 1)) begin
      slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
      slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    result_d = result_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    cu_d     = cu_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          signed_d = is_signed;
          idx_d    = IDXW'(NCHUNK - 1);
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (slice_a != slice_b || idx_q == '0) begin
          lt_d     = slice_a < slice_b;
          eq_d     = slice_a == slice_b;
          result_d = eval_op(op_q, lt_d, eq_d);
          cu_d     = CUW'(NCHUNK) - CUW'(idx_q);
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      result_q <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cu_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      cu_q     <= cu_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign lt_flag     = lt_q;
  assign eq_flag     = eq_q;
  assign chunks_used = cu_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator. It runs directed cases on a 32/8 instance and
// random ops on a 64/16 instance, and checks both against a behavioural model.
module tb_seq_magnitude_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        iv0 = 1'b0, iv1 = 1'b0, out_ready = 1'b0, sgn_drv = 1'b0, sel64 = 1'b0;
  logic [63:0] a_drv = '0, b_drv = '0;
  logic [2:0]  op_drv = '0;

  logic ir0, ov0, r0, lt0, eq0, ir1, ov1, r1, lt1, eq1;
  logic [2:0] cu0, cu1;
  logic [1:0] st0, st1;
  logic o_ir, o_ov, o_r, o_lt, o_eq;
  logic [2:0] o_cu;

  int n_cmp = 0;
  int n_bad = 0;

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a_drv[31:0]), .b(b_drv[31:0]),
    .op(op_drv), .is_signed(sgn_drv), .out_valid(ov0), .out_ready(out_ready), .result(r0),
    .lt_flag(lt0), .eq_flag(eq0), .chunks_used(cu0), .dbg_state_o(st0)
  );

  seq_magnitude_comparator #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_drv), .b(b_drv),
    .op(op_drv), .is_signed(sgn_drv), .out_valid(ov1), .out_ready(out_ready), .result(r1),
    .lt_flag(lt1), .eq_flag(eq1), .chunks_used(cu1), .dbg_state_o(st1)
  );

  assign o_ir = sel64 ? ir1 : ir0;
  assign o_ov = sel64 ? ov1 : ov0;
  assign o_r  = sel64 ? r1  : r0;
  assign o_lt = sel64 ? lt1 : lt0;
  assign o_eq = sel64 ? eq1 : eq0;
  assign o_cu = sel64 ? cu1 : cu0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of run, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Relation computed on the true numeric values; slice count from the highest differing bit.
  function automatic void model(input int w, input int ch, input logic [63:0] a_in,
                                input logic [63:0] b_in, input logic [2:0] op,
                                input logic sgn, output logic r, output logic lt,
                                output logic eq, output int cu);
    logic [63:0] mask, a, b, x;
    logic signed [64:0] sa, sb;
    int top;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = (sgn && a[w-1]) ? $signed({1'b1, a | ~mask}) : $signed({1'b0, a});
    sb = (sgn && b[w-1]) ? $signed({1'b1, b | ~mask}) : $signed({1'b0, b});
    lt = sa < sb;
    eq = (a == b);
    x = a ^ b;
    top = -1;
    for (int i = 0; i < w; i++) if (x[i]) top = i;
    cu = (top < 0) ? w / ch : w / ch - top / ch;
    case (op)
      3'd0: r = lt;
      3'd1: r = lt | eq;
      3'd2: r = !lt && !eq;
      3'd3: r = !lt;
      3'd4: r = eq;
      3'd5: r = !eq;
      default: r = 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // lat counts rising edges from the accepting edge (inclusive) up to the one raising out_valid.
  task automatic start_op(input logic w64, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op, input logic sgn, output int lat);
    @(negedge clk);
    sel64 = w64; a_drv = a; b_drv = b; op_drv = op; sgn_drv = sgn;
    check("in_ready_before_accept", 64'(o_ir), 64'd1);
    iv0 = !w64;
    iv1 = w64;
    @(posedge clk); #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    lat = 1;
    while (!o_ov && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_ov) check("out_valid_timeout", 64'(o_ov), 64'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_consume", 64'(o_ov), 64'd0);
    check("in_ready_after_consume", 64'(o_ir), 64'd1);
  endtask

  task automatic expect_out(input string tag, input logic r, input logic lt, input logic eq,
                            input int cu);
    check({tag, "_result"}, 64'(o_r), 64'(r));
    check({tag, "_lt"}, 64'(o_lt), 64'(lt));
    check({tag, "_eq"}, 64'(o_eq), 64'(eq));
    check({tag, "_cu"}, 64'(o_cu), 64'(cu));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    logic [63:0] ra, rb;
    logic [2:0] rop;
    logic rsgn, m_r, m_lt, m_eq;
    int m_cu, k;
    logic [5:0] eq_exp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #0;
      check("reset_in_ready", 64'(o_ir), 64'd1);
      check("reset_out_valid", 64'(o_ov), 64'd0);
      expect_out("reset", 1'b0, 1'b0, 1'b0, 0);
    end

    start_op(1'b0, 64'h5, 64'h7, 3'd0, 1'b0, lat);
    expect_out("lt_5_7", 1'b1, 1'b1, 1'b0, 4);
    check("lt_5_7_latency", 64'(lat), 64'd5);
    consume();

    start_op(1'b0, 64'h8000_0000, 64'h1, 3'd0, 1'b0, lat);
    expect_out("unsigned_msb", 1'b0, 1'b0, 1'b0, 1);
    check("unsigned_msb_latency", 64'(lat), 64'd2);
    consume();

    start_op(1'b0, 64'h8000_0000, 64'h1, 3'd0, 1'b1, lat);
    expect_out("signed_msb", 1'b1, 1'b1, 1'b0, 1);
    consume();

    eq_exp = 6'b011010;  // bit n is the expected result of op n for equal operands
    for (int o = 0; o < 6; o++) begin
      start_op(1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 3'(o), 1'b0, lat);
      expect_out($sformatf("equal_op%0d", o), eq_exp[o], 1'b0, 1'b1, 4);
      consume();
    end

    // Backpressure: the result holds, and a request pulse during DONE is dropped.
    start_op(1'b0, 64'h10, 64'h20, 3'd2, 1'b0, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        a_drv = 64'hFFFF_FFFF; b_drv = 64'h0; op_drv = 3'd4; iv0 = 1'b1;
      end else begin
        iv0 = 1'b0;
      end
      check("bp_out_valid", 64'(o_ov), 64'd1);
      check("bp_in_ready", 64'(o_ir), 64'd0);
      expect_out("bp_hold", 1'b0, 1'b1, 1'b0, 4);
    end
    consume();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_not_queued", 64'(o_ov), 64'd0);
      check("bp_idle_ready", 64'(o_ir), 64'd1);
    end

    // Reset in the second SCAN cycle aborts the op.
    @(negedge clk);
    sel64 = 1'b0; a_drv = 64'h5; b_drv = 64'h7; op_drv = 3'd0; sgn_drv = 1'b0; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(o_ov), 64'd0);
    check("abort_in_ready", 64'(o_ir), 64'd1);
    expect_out("abort", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_result", 64'(o_ov), 64'd0);
    end
    start_op(1'b0, 64'h3, 64'h2, 3'd2, 1'b0, lat);
    expect_out("after_abort_gt", 1'b1, 1'b0, 1'b0, 4);
    consume();

    start_op(1'b0, 64'h1, 64'h2, 3'd6, 1'b0, lat);
    expect_out("reserved_op", 1'b0, 1'b1, 1'b0, 4);
    consume();

    // Random ops on the 64/16 instance; b shares a random number of top slices with a.
    for (int n = 0; n < 10000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      k = $urandom_range(0, 4);
      for (int s = 0; s < k; s++) rb[63 - 16*s -: 16] = ra[63 - 16*s -: 16];
      rop = 3'($urandom_range(0, 7));
      rsgn = 1'($urandom_range(0, 1));
      model(64, 16, ra, rb, rop, rsgn, m_r, m_lt, m_eq, m_cu);
      start_op(1'b1, ra, rb, rop, rsgn, lat);
      expect_out($sformatf("rand%0d_a%0h_b%0h_op%0d_s%0d", n, ra, rb, rop, rsgn),
                 m_r, m_lt, m_eq, m_cu);
      check("rand_latency", 64'(lat), 64'(m_cu + 1));
      check("rand_cu_bound", 64'(o_cu <= 3'd4), 64'd1);
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-mode successor to the fixed 32-bit unsigned less-than comparator.
- Compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per cycle, and stops early at the first differing slice.
- Supports signed and unsigned operands and six relational ops. Uses valid/ready handshakes on both sides.
- Sits between operand registers and downstream control logic where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK; otherwise elaboration fails.
- CHUNK, 8, bits compared per cycle. 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK (derived, localparam), number of slices.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand/op request valid.
- in_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- op  in  3  relation: 0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6-7 reserved.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1  evaluated relation (a op b).
- lt_flag  out  1  a < b under the captured signedness.
- eq_flag  out  1  a == b.
- chunks_used  out  $clog2(NCHUNK+1)  slices examined for this result (1..NCHUNK).

Behaviour:
- Reset, applied asynchronously:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - result, lt_flag, eq_flag, chunks_used = 0.
  - captured operands cleared.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b, op, is_signed. Set idx = NCHUNK-1 and go to SCAN.
- SCAN:
  - in_ready = 0.
  - Each cycle, compare slice idx, i.e. bits [idx*CHUNK +: CHUNK].
  - Top slice (idx = NCHUNK-1) with is_signed = 1: invert bit CHUNK-1 of both slices before the unsigned compare.
  - Slices differ: set lt_flag = (slice_a < slice_b), eq_flag = 0, go to DONE.
  - Slices equal and idx = 0: set lt_flag = 0, eq_flag = 1, go to DONE.
  - Otherwise: idx = idx-1 and stay in SCAN.
  - chunks_used = NCHUNK - idx at the deciding slice.
- DONE:
  - out_valid = 1. result, lt_flag, eq_flag and chunks_used are held stable until out_ready.
  - result = LT: lt; LE: lt|eq; GT: ~lt&~eq; GE: ~lt; EQ: eq; NE: ~eq; reserved ops: 0. Flags remain meaningful for reserved ops.
  - On out_ready: out_valid falls next cycle and the FSM returns to IDLE.
- Latency:
  - out_valid rises j+1 rising edges after the accepting edge, where j = chunks_used.
  - Minimum 2 cycles, maximum NCHUNK+1.
- Throughput:
  - One op per j+2 cycles with out_ready held high.
  - A new request cannot be accepted in the same cycle the result is consumed.
- in_valid and operand changes while in SCAN or DONE are ignored and do not disturb captured values.
- out_ready while out_valid = 0 has no effect.
- Reset during SCAN or DONE aborts the op; no result is ever emitted for it.
- CHUNK = WIDTH: every op decides in 1 slice, latency 2.
- CHUNK = 1 with signed operands: the sign-bit inversion applies to the single MSB bit.
- Outputs are registered; there is no combinational path from in_* to out_*.

Test Plan:
- WIDTH=32, CHUNK=8, unsigned LT, a=0x00000005, b=0x00000007 -> result=1, lt_flag=1, eq_flag=0, chunks_used=4, out_valid 5 edges after accept.
- a=0x80000000, b=0x00000001, op LT:
  - unsigned -> result=0, chunks_used=1, latency 2.
  - signed -> result=1, lt_flag=1.
- a=b=0xDEADBEEF, one request per op:
  - EQ=1, LE=1, GE=1, LT=0, GT=0, NE=0.
  - eq_flag=1 and chunks_used=4 for each.
- Backpressure: out_ready held low 10 cycles after out_valid.
  - result and flags hold stable; in_ready=0.
  - A new in_valid pulse is ignored and not queued.
  - After out_ready: in_ready=1 within 1 cycle.
- Assert rst for 1 cycle in the 2nd SCAN cycle -> out_valid, result and flags read 0 immediately, in_ready=1. The next op (a=3, b=2, GT) yields result=1.
- Reserved op=6 with a=1, b=2 -> result=0, lt_flag=1.
- Rebuild at WIDTH=64, CHUNK=16 and run 10k random signed/unsigned ops against a behavioural model: all results match and chunks_used <= 4.
